// File: rtl/stereo_audio_serializer.sv
// Stereo pair to serial sample serializer: accepts one left/right pair and
// emits left then right on a valid/ready stream with one cycle of latency.
module stereo_audio_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_left,
  output logic [WIDTH-1:0] o_audio
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] right_q;
  logic             in_hs_s;

  // The held left sample lives in o_audio, so only the right half needs storage.
  always_comb begin
    i_ready = 1'b0;
    if (reset) begin
      i_ready = 1'b0;
    end else begin
      case (state_q)
        EMPTY:   i_ready = 1'b1;
        RIGHT:   i_ready = o_ready;
        LEFT:    i_ready = 1'b0;
        default: i_ready = 1'b0;
      endcase
    end
  end

  assign in_hs_s = i_valid && i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      o_valid   <= 1'b0;
      o_is_left <= 1'b1;
      o_audio   <= {WIDTH{1'b0}};
      right_q   <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs_s) begin
            state_q   <= LEFT;
            o_valid   <= 1'b1;
            o_is_left <= 1'b1;
            o_audio   <= i_left;
            right_q   <= i_right;
          end
        end
        LEFT: begin
          if (o_ready) begin
            state_q   <= RIGHT;
            o_is_left <= 1'b0;
            o_audio   <= right_q;
          end
        end
        RIGHT: begin
          if (o_ready) begin
            if (in_hs_s) begin
              // Next pair enters directly behind the outgoing right sample.
              state_q   <= LEFT;
              o_valid   <= 1'b1;
              o_is_left <= 1'b1;
              o_audio   <= i_left;
              right_q   <= i_right;
            end else begin
              state_q   <= EMPTY;
              o_valid   <= 1'b0;
              o_is_left <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= EMPTY;
          o_valid   <= 1'b0;
          o_is_left <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_audio_serializer.sv
// Bench for stereo_audio_serializer: directed scenarios plus a queue-based
// scoreboard that follows every input and output handshake.
module tb_stereo_audio_serializer;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_left;
  logic [W-1:0] i_right;
  logic         o_valid;
  logic         o_ready;
  logic         o_is_left;
  logic [W-1:0] o_audio;

  int total;
  int bad;
  int in_cnt;
  int out_cnt;
  logic [W:0] sb[$];

  stereo_audio_serializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_left   (i_left),
    .i_right  (i_right),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_is_left(o_is_left),
    .o_audio  (o_audio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each accepted pair queues L then R; each output handshake pops one.
  always @(negedge clk) begin
    logic [W:0] exp_e;
    if (reset) begin
      sb.delete();
    end else begin
      if (o_valid && o_ready) begin
        out_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got is_left=%0b audio=%h, required no output", o_is_left, o_audio);
        end else begin
          exp_e = sb.pop_front();
          if ({o_is_left, o_audio} !== exp_e) begin
            bad++;
            $display("FAIL sb_data: got is_left=%0b audio=%h, required is_left=%0b audio=%h",
                     o_is_left, o_audio, exp_e[W], exp_e[W-1:0]);
          end
        end
      end
      if (i_valid && i_ready) begin
        sb.push_back({1'b1, i_left});
        sb.push_back({1'b0, i_right});
        in_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    i_left = '0; i_right = '0;
    tick(); tick();
    @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid: got %0b required 0", o_valid); end
    total++; if (o_is_left !== 1'b1) begin bad++; $display("FAIL rst_o_is_left: got %0b required 1", o_is_left); end
    total++; if (o_audio !== 32'h0) begin bad++; $display("FAIL rst_o_audio: got %h required 0", o_audio); end
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL rst_i_ready: got %0b required 0", i_ready); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rst_release_i_ready: got %0b required 1", i_ready); end
    tick();
  endtask

  task automatic test_basic_pair();
    o_ready = 1'b1; i_valid = 1'b1;
    i_left = 32'h00010000; i_right = 32'h1fed1fed;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b1, 32'h00010000}) begin
      bad++; $display("FAIL basic_left: got v=%0b l=%0b a=%h required v=1 l=1 a=00010000", o_valid, o_is_left, o_audio); end
    tick();
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b0, 32'h1fed1fed}) begin
      bad++; $display("FAIL basic_right: got v=%0b l=%0b a=%h required v=1 l=0 a=1fed1fed", o_valid, o_is_left, o_audio); end
    tick();
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b0, 1'b1, 32'h1fed1fed}) begin
      bad++; $display("FAIL basic_idle: got v=%0b l=%0b a=%h required v=0 l=1 a=1fed1fed", o_valid, o_is_left, o_audio); end
    tick();
  endtask

  task automatic test_streaming();
    logic [W-1:0] sl[3];
    logic [W-1:0] sr[3];
    logic [W-1:0] exp_seq[6];
    logic hs;
    int k;
    sl[0] = 32'h2eef2eef; sr[0] = 32'h33333333;
    sl[1] = 32'h12345678; sr[1] = 32'h1fed1fed;
    sl[2] = 32'h99911223; sr[2] = 32'hABCDEF01;
    for (int j = 0; j < 3; j++) begin
      exp_seq[2*j] = sl[j];
      exp_seq[2*j+1] = sr[j];
    end
    k = 0;
    o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (k < 3) begin
        i_valid = 1'b1; i_left = sl[k]; i_right = sr[k];
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        total++;
        if ({o_valid, o_is_left, o_audio} !== {1'b1, (c % 2 == 1), exp_seq[c-1]}) begin
          bad++;
          $display("FAIL stream_c%0d: got v=%0b l=%0b a=%h required v=1 l=%0b a=%h",
                   c, o_valid, o_is_left, o_audio, (c % 2 == 1), exp_seq[c-1]);
        end
      end else if (c == 7) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_end: got v=%0b required 0", o_valid); end
      end
      hs = i_valid && i_ready;
      tick();
      if (hs) k++;
    end
  endtask

  task automatic test_backpressure();
    o_ready = 1'b0; i_valid = 1'b1;
    i_left = 32'h55555555; i_right = 32'h44444444;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_is_left, o_audio, i_ready} !== {1'b1, 1'b1, 32'h55555555, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got v=%0b l=%0b a=%h ir=%0b required v=1 l=1 a=55555555 ir=0",
                 c, o_valid, o_is_left, o_audio, i_ready);
      end
      tick();
    end
    o_ready = 1'b1;
    tick();
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b0, 32'h44444444}) begin
      bad++; $display("FAIL bp_right: got v=%0b l=%0b a=%h required v=1 l=0 a=44444444", o_valid, o_is_left, o_audio); end
    tick();
  endtask

  task automatic test_right_stall();
    o_ready = 1'b1; i_valid = 1'b1;
    i_left = 32'hA1A1A1A1; i_right = 32'hA2A2A2A2;
    tick();
    i_left = 32'hB1B1B1B1; i_right = 32'hB2B2B2B2;
    tick();
    o_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({i_ready, o_valid, o_is_left, o_audio} !== {1'b0, 1'b1, 1'b0, 32'hA2A2A2A2}) begin
        bad++;
        $display("FAIL rstall_hold_%0d: got ir=%0b v=%0b l=%0b a=%h required ir=0 v=1 l=0 a=a2a2a2a2",
                 c, i_ready, o_valid, o_is_left, o_audio);
      end
      tick();
    end
    o_ready = 1'b1;
    @(negedge clk);
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rstall_ready: got %0b required 1", i_ready); end
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b1, 32'hB1B1B1B1}) begin
      bad++; $display("FAIL rstall_next: got v=%0b l=%0b a=%h required v=1 l=1 a=b1b1b1b1", o_valid, o_is_left, o_audio); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_pair();
    o_ready = 1'b1; i_valid = 1'b1;
    i_left = 32'hC1C1C1C1; i_right = 32'hC2C2C2C2;
    tick();
    i_valid = 1'b0;
    tick();
    reset = 1'b1; o_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({o_valid, o_audio, o_is_left, i_ready} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_state: got v=%0b a=%h l=%0b ir=%0b required v=0 a=0 l=1 ir=0",
               o_valid, o_audio, o_is_left, i_ready);
    end
    reset = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    total++; if ({i_ready, o_valid} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL midrst_release: got ir=%0b v=%0b required ir=1 v=0", i_ready, o_valid); end
    i_valid = 1'b1; i_left = 32'hD1D1D1D1; i_right = 32'hD2D2D2D2;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    total++; if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b1, 32'hD1D1D1D1}) begin
      bad++; $display("FAIL midrst_next: got v=%0b l=%0b a=%h required v=1 l=1 a=d1d1d1d1", o_valid, o_is_left, o_audio); end
    tick(); tick();
  endtask

  task automatic test_random();
    int acc;
    int cyc;
    int out0;
    logic have;
    logic hs;
    acc = 0; cyc = 0; have = 1'b0;
    out0 = out_cnt;
    while (acc < 1000 && cyc < 20000) begin
      if (!have) begin
        i_left = $urandom; i_right = $urandom; have = 1'b1;
      end
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = i_valid && i_ready;
      tick();
      cyc++;
      if (hs) begin acc++; have = 1'b0; end
    end
    total++; if (acc != 1000) begin bad++; $display("FAIL rand_timeout: got %0d pairs required 1000", acc); end
    i_valid = 1'b0; o_ready = 1'b1;
    repeat (4) tick();
    total++; if ((out_cnt - out0) != 2 * acc) begin
      bad++; $display("FAIL rand_count: got %0d outputs required %0d", out_cnt - out0, 2 * acc); end
    total++; if (sb.size() != 0) begin
      bad++; $display("FAIL rand_leftover: got %0d pending required 0", sb.size()); end
  endtask

  initial begin
    total = 0; bad = 0; in_cnt = 0; out_cnt = 0;
    test_reset();
    test_basic_pair();
    test_streaming();
    test_backpressure();
    test_right_stall();
    test_reset_mid_pair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stereo_audio_serializer.md
STEREO_AUDIO_SERIALIZER -- requirements
Module: stereo_audio_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the sample width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit: a stereo pair is present on i_left/i_right.
REQ-005 The block SHALL have port i_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-006 The block SHALL have port i_left, input, WIDTH bits: left sample of the pair.
REQ-007 The block SHALL have port i_right, input, WIDTH bits: right sample of the pair.
REQ-008 The block SHALL have port o_valid, output, 1 bit: a serial sample is present on o_audio.
REQ-009 The block SHALL have port o_ready, input, 1 bit: the downstream sink takes the sample this cycle.
REQ-010 The block SHALL have port o_is_left, output, 1 bit: 1 means o_audio is a left sample, 0 means right.
REQ-011 The block SHALL have port o_audio, output, WIDTH bits: the serial sample.

Function
REQ-012 An input handshake SHALL be i_valid && i_ready at a rising clk edge, and an output handshake SHALL be o_valid && o_ready at a rising clk edge.
REQ-013 The FSM SHALL have exactly three states: EMPTY (no pair held), LEFT (presenting the held left sample), RIGHT (presenting the held right sample).
REQ-014 On an input handshake the block SHALL capture i_left/i_right into an internal pair register and enter LEFT.
REQ-015 In LEFT the block SHALL drive o_valid=1, o_is_left=1, o_audio=held left; an output handshake SHALL move the FSM to RIGHT.
REQ-016 In RIGHT the block SHALL drive o_valid=1, o_is_left=0, o_audio=held right.
REQ-017 On an output handshake in RIGHT with no simultaneous input handshake, the FSM SHALL go to EMPTY.
REQ-018 On an output handshake in RIGHT with a simultaneous input handshake, the FSM SHALL go to LEFT with the new pair and no idle cycle.
REQ-019 i_ready SHALL be 1 in EMPTY, SHALL equal o_ready in RIGHT, and SHALL be 0 in LEFT.
REQ-020 i_ready SHALL be the only combinational input-to-output path (o_ready to i_ready); o_valid, o_is_left and o_audio SHALL be registered.
REQ-021 Latency SHALL be one cycle: the left sample appears with o_valid=1 in the cycle after its input handshake.
REQ-022 Sustained throughput SHALL be one sample per cycle (one pair per two cycles) when i_valid and o_ready are both held at 1.
REQ-023 While o_valid=1 and o_ready=0, o_audio, o_is_left and the held pair SHALL remain unchanged (backpressure stall, unlimited duration).
REQ-024 In EMPTY, o_valid SHALL be 0, o_audio SHALL hold its last value, and o_is_left SHALL be 1.
REQ-025 Samples SHALL pass bit-exact with no arithmetic, truncation or sign handling, and output order SHALL always be left then right of the same pair.
REQ-026 i_valid while i_ready=0 SHALL be ignored without loss; the source holds the pair until its handshake.

Reset
REQ-027 While reset=1 at a rising edge the FSM SHALL enter EMPTY, o_valid SHALL become 0, o_is_left SHALL become 1, and o_audio SHALL become 0.
REQ-028 While reset=1, i_ready SHALL be 0.
REQ-029 Reset asserted mid-pair (in LEFT or RIGHT) SHALL discard the held pair; after reset deasserts, no stale right sample SHALL be emitted.

Verification
REQ-030 Basic pair: with o_ready=1, one handshake of L=32'h00010000, R=32'h1fed1fed SHALL produce (is_left=1, 00010000) then (is_left=0, 1fed1fed) on consecutive cycles, then o_valid=0.
REQ-031 Streaming: with i_valid and o_ready held at 1 for pairs (2eef2eef,33333333), (12345678,1fed1fed), (99911223,ABCDEF01), the bench SHALL see six back-to-back samples in L,R order with no bubble.
REQ-032 Backpressure: o_ready=0 for 4 cycles while LEFT shows 55555555 SHALL hold o_audio=55555555, is_left=1 and i_ready=0; then 44444444 (right) SHALL follow when o_ready=1.
REQ-033 Stall in RIGHT: o_ready=0 in RIGHT with the next pair waiting SHALL keep i_ready=0; raising o_ready SHALL complete the right sample and accept the next pair in the same cycle.
REQ-034 Reset mid-pair: reset asserted in RIGHT for 2 cycles SHALL yield o_valid=0, o_audio=0, o_is_left=1, i_ready=0; after release, i_ready=1 and the next output SHALL be the left sample of a new pair.
REQ-035 Scoreboard: 1000 random pairs with random i_valid/o_ready SHALL yield output count = 2 × accepted pairs, strict L/R alternation starting with L, and bit-exact data.
